// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and widths for the unified memory port arbiter
package arm_mem_pkg;
  localparam int WORD_W = 32;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} arb_owner_t;
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter that flags when the memory data is due
module mem_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between fetch (I) and data (D)
module mem_port_arbiter import arm_mem_pkg::*; #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m
);
  localparam int CW = $clog2(MEM_LATENCY) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic we_q, we_d, byte_q, byte_d;
  logic wait_zero, force_i, sel_d, grant, done;
  // D wins ties unless fetch has been passed over STARVE_LIMIT times in a row
  assign force_i = i_req && starve_q == SW'(STARVE_LIMIT);
  assign sel_d   = d_req && !force_i;
  assign grant   = state_q == IDLE && (i_req || d_req) && !reset;
  assign done    = state_q == BUSY && wait_zero;
  mem_wait_counter #(.W(CW)) u_wait (
    .clk        (clk),
    .rst        (reset),
    .load_i     (grant),
    .load_val_i (CW'(MEM_LATENCY - 1)),
    .dec_i      (state_q == BUSY),
    .zero_o     (wait_zero)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  always_comb state_d = (state_q == IDLE) ? (grant ? BUSY : IDLE) : (wait_zero ? IDLE : BUSY);
  always_comb begin
    mem_en    = grant;
    mem_we    = grant && sel_d && d_we;
    mem_byte  = grant && sel_d && d_byte;
    mem_addr  = grant ? (sel_d ? d_addr : i_addr) : addr_q;
    mem_wdata = grant ? (sel_d ? d_wdata : '0) : wdata_q;
    i_ready   = done && owner_q == OWN_I;
    d_ready   = done && owner_q == OWN_D;
    i_rdata   = i_ready ? mem_rdata : '0;
    d_rdata   = (d_ready && !we_q) ? mem_rdata : '0;
  end
  assign stall_f = i_req & ~i_ready;
  assign stall_m = d_req & ~d_ready;
  always_comb begin
    owner_d  = grant ? (sel_d ? OWN_D : OWN_I) : done ? OWN_NONE : owner_q;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    we_d     = grant ? mem_we : we_q;
    byte_d   = grant ? mem_byte : byte_q;
    starve_d = !grant ? starve_q : (sel_d && i_req) ? starve_q + SW'(1) : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a transaction-level model
module tb_mem_port_arbiter;
  localparam int L = 2, LIM = 4;
  logic clk = 0, reset = 1;
  logic i_req = 0, d_req = 0, d_we = 0, d_byte = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic i_ready, d_ready, mem_en, mem_we, mem_byte, stall_f, stall_m;
  logic b_i_req = 0, b_d_req = 0, b_d_we = 0, b_d_byte = 0;
  logic [31:0] b_i_addr = 0, b_d_addr = 0, b_d_wdata = 0, b_mem_rdata = 0;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic b_i_ready, b_d_ready, b_mem_en, b_mem_we, b_mem_byte, b_stall_f, b_stall_m;
  int ncmp = 0, nfail = 0;
  int cyc, m_done, m_own, m_starve, obs_i, obs_d, g, nd;
  logic [31:0] m_addr;
  logic m_we;
  bit seen;

  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_ready(i_ready), .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready), .mem_en(mem_en),
    .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m));

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(LIM)) dut1 (
    .clk(clk), .reset(reset), .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata),
    .i_ready(b_i_ready), .d_req(b_d_req), .d_we(b_d_we), .d_byte(b_d_byte), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_ready(b_d_ready), .mem_en(b_mem_en),
    .mem_we(b_mem_we), .mem_byte(b_mem_byte), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_f(b_stall_f), .stall_m(b_stall_m));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_done = -1; m_own = 0; m_starve = 0; m_addr = 0; m_we = 0;
  endtask

  // Transaction view: an access granted in cycle c owns the memory until it completes at c+L
  task automatic cyc_check();
    bit idle, gnt, sd, rdy;
    logic [31:0] rv;
    idle = cyc > m_done;
    gnt  = idle && (i_req || d_req);
    sd   = d_req && !(i_req && m_starve == LIM);
    rdy  = cyc == m_done;
    rv   = m_we ? 32'h0 : mem_rdata;
    chk("mem_en", mem_en, gnt);
    chk("mem_we", mem_we, gnt && sd && d_we);
    chk("mem_byte", mem_byte, gnt && sd && d_byte);
    if (gnt || !idle) chk("mem_addr", mem_addr, gnt ? (sd ? d_addr : i_addr) : m_addr);
    if (gnt) chk("mem_wdata", mem_wdata, sd ? d_wdata : 32'h0);
    chk("i_ready", i_ready, rdy && m_own == 1);
    chk("d_ready", d_ready, rdy && m_own == 2);
    chk("i_rdata", i_rdata, (rdy && m_own == 1) ? mem_rdata : 32'h0);
    chk("d_rdata", d_rdata, (rdy && m_own == 2) ? rv : 32'h0);
    chk("stall_f", stall_f, i_req && !(rdy && m_own == 1));
    chk("stall_m", stall_m, d_req && !(rdy && m_own == 2));
    if (i_ready) obs_i = cyc;
    if (d_ready) obs_d = cyc;
    if (gnt) begin
      m_done   = cyc + L;
      m_own    = sd ? 2 : 1;
      m_addr   = sd ? d_addr : i_addr;
      m_we     = sd && d_we;
      m_starve = (sd && i_req) ? m_starve + 1 : 0;
    end
    cyc++;
  endtask

  task automatic fin();
    cyc_check();
    @(posedge clk); #1;
    mem_rdata = $urandom;
  endtask

  task automatic cycle();
    @(negedge clk);
    fin();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_byte", mem_byte, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_irdy", i_ready, 0);
    chk("rst_drdy", d_ready, 0);
    chk("rst_irdata", i_rdata, 0);
    chk("rst_drdata", d_rdata, 0);
    chk("rst_stall_f", stall_f, 0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    // single fetch
    i_req = 1; i_addr = 32'h100;
    @(negedge clk); chk("A_en_t0", mem_en, 1); chk("A_stall_t0", stall_f, 1); fin();
    @(negedge clk); chk("A_en_t1", mem_en, 0); chk("A_stall_t1", stall_f, 1); fin();
    mem_rdata = 32'hE3A01005;
    @(negedge clk);
    chk("A_iready_t2", i_ready, 1);
    chk("A_irdata", i_rdata, 32'hE3A01005);
    chk("A_stall_t2", stall_f, 0);
    fin();
    i_req = 0;
    cycle();
    // simultaneous I and D
    g = cyc; obs_i = -100; obs_d = -100;
    i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h200; d_we = 0; d_byte = 0;
    for (int k = 0; k < 12 && (i_req || d_req); k++) begin
      @(negedge clk);
      fin();
      if (obs_d >= g) d_req = 0;
      if (obs_i >= g) i_req = 0;
    end
    chk("B_dready_lat", obs_d - g, 2);
    chk("B_iready_lat", obs_i - g, 5);
    // byte store with inputs changing mid-access
    d_req = 1; d_we = 1; d_byte = 1; d_wdata = 32'hAB; d_addr = 32'h203;
    @(negedge clk);
    chk("C_en", mem_en, 1);
    chk("C_we", mem_we, 1);
    chk("C_byte", mem_byte, 1);
    chk("C_addr", mem_addr, 32'h203);
    chk("C_wdata", mem_wdata, 32'hAB);
    fin();
    d_wdata = 32'h55; d_addr = 32'h999;
    @(negedge clk); chk("C_addr_held", mem_addr, 32'h203); fin();
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk); chk("C_dready", d_ready, 1); chk("C_drdata", d_rdata, 0); fin();
    d_req = 0; d_we = 0; d_byte = 0;
    cycle();
    // starvation: twice in a row proves the counter clears on the I grant
    i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h2000;
    for (int r = 0; r < 2; r++) begin
      nd = 0; seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (mem_en && mem_addr == 32'h2000) nd++;
        if (i_ready) seen = 1;
        fin();
      end
      chk("D_dgrants", nd, 4);
      chk("D_i_served", seen, 1);
    end
    i_req = 0; d_req = 0;
    cycle();
    // reset while BUSY with one wait cycle left
    d_req = 1; d_addr = 32'h300;
    @(negedge clk); chk("E_en", mem_en, 1); fin();
    reset = 1; d_req = 0;
    #1;
    chk("E_addr_rst", mem_addr, 0);
    chk("E_en_rst", mem_en, 0);
    chk("E_drdy_rst", d_ready, 0);
    chk("E_irdy_rst", i_ready, 0);
    chk("E_drdata_rst", d_rdata, 0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    obs_i = -100; obs_d = -100;
    repeat (4) cycle();
    chk("E_no_dready", obs_d, -100);
    chk("E_no_iready", obs_i, -100);
    g = cyc; i_req = 1; i_addr = 32'h400;
    for (int k = 0; k < 10 && i_req; k++) begin
      @(negedge clk);
      fin();
      if (obs_i >= g) i_req = 0;
    end
    chk("E_restart_lat", obs_i - g, 2);
    cycle();
    // randomized traffic, requests may drop or change at any time
    repeat (400) begin
      i_req   = $urandom_range(0, 3) != 0;
      d_req   = $urandom_range(0, 4) != 0;
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = 1'($urandom_range(0, 1));
      d_byte  = 1'($urandom_range(0, 1));
      cycle();
    end
    i_req = 0; d_req = 0; d_we = 0; d_byte = 0;
    cycle();
    // latency-1 build: back-to-back fetches every two cycles
    b_i_req = 1; b_i_addr = 32'h40;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("G_en", b_mem_en, (k % 2) == 0);
      chk("G_rdy", b_i_ready, (k % 2) == 1);
      chk("G_stall_f", b_stall_f, (k % 2) == 0);
      chk("G_addr", b_mem_addr, 32'h40);
      chk("G_rdata", b_i_rdata, ((k % 2) == 1) ? b_mem_rdata : 32'h0);
      chk("G_dside", {b_d_ready, b_stall_m, b_mem_we, b_mem_byte}, 0);
      chk("G_zero", b_mem_wdata | b_d_rdata, 0);
      @(posedge clk); #1;
      b_mem_rdata = $urandom;
    end
    b_i_req = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
